// File: rtl/robertson_pkg.sv
// Shared definitions for the Robertson sequential signed multiplier.
//   state_t  : controller states
//   OP_*     : operation codes driven on op_sel toward the downstream 5:1 mux
package robertson_pkg;

   localparam int OP_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [OP_W-1:0] OP_LOAD  = 3'd0;
   localparam logic [OP_W-1:0] OP_ADD   = 3'd1;
   localparam logic [OP_W-1:0] OP_SHIFT = 3'd2;
   localparam logic [OP_W-1:0] OP_SUB   = 3'd3;
   localparam logic [OP_W-1:0] OP_HOLD  = 3'd4;

endpackage

// File: rtl/robertson_addsub.sv
// Combinational W-bit adder/subtractor used for the partial-product update.
//   x, y : operands
//   sub  : 1 -> x - y, 0 -> x + y
//   sum  : result, same width as the operands
module robertson_addsub #(
   parameter int W = 9
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         sub,
   output logic [W-1:0] sum
);

   assign sum = sub ? (x - y) : (x + y);

endmodule

// File: rtl/robertson_seq.sv
// Sequential signed multiplier, Robertson add-shift, one multiplier bit per clock.
//   clk, reset : system clock, synchronous active-high reset
//   start      : request, only honoured in IDLE
//   a, b       : signed multiplicand / multiplier, captured on accepted start
//   busy       : high while stepping (RUN)
//   done       : one-cycle pulse when product is freshly valid
//   product    : signed 2N-bit result, held until the next final step or reset
//   op_sel     : current-cycle operation code for the downstream 5:1 mux
//
// state | meaning
// IDLE  | waiting for start; op_sel = LOAD when start is high, else HOLD
// RUN   | N add/sub + arithmetic-shift steps, count N-1 down to 0
// DONE  | product valid, done pulse, back to IDLE next cycle
module robertson_seq
   import robertson_pkg::*;
#(
   parameter int N = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [N-1:0]    a,
   input  logic [N-1:0]    b,
   output logic            busy,
   output logic            done,
   output logic [2*N-1:0]  product,
   output logic [OP_W-1:0] op_sel
);

   localparam int CW = $clog2(N);

   state_t        state;
   logic [N:0]    acc;
   logic [N:0]    m_ext;
   logic [N-1:0]  q;
   logic          f;
   logic [CW-1:0] count;

   logic          q0;
   logic          last;
   logic [N:0]    sum;
   logic [N:0]    acc_new;
   logic          f_new;
   logic          sign_new;
   logic [N:0]    acc_sh;
   logic [N-1:0]  q_sh;

   assign q0   = q[0];
   assign last = (count == '0);

   // The last multiplier bit carries negative weight, so it subtracts M.
   robertson_addsub #(.W(N+1)) u_addsub (
      .x   (acc),
      .y   (m_ext),
      .sub (last),
      .sum (sum)
   );

   assign acc_new = q0 ? sum : acc;
   // F latches once a negative multiplicand has been accumulated; from then on
   // the partial product is negative and F supplies the shifted-in sign.
   assign f_new    = f | (m_ext[N] & q0);
   assign sign_new = last ? acc_new[N] : f_new;
   assign acc_sh   = {sign_new, acc_new[N:1]};
   assign q_sh     = {acc_new[0], q[N-1:1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         acc     <= '0;
         m_ext   <= '0;
         q       <= '0;
         f       <= 1'b0;
         count   <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  m_ext <= {a[N-1], a};
                  q     <= b;
                  acc   <= '0;
                  f     <= 1'b0;
                  count <= CW'(N-1);
                  state <= RUN;
               end
            end
            RUN: begin
               acc   <= acc_sh;
               q     <= q_sh;
               f     <= f_new;
               count <= count - CW'(1);
               if (last) begin
                  product <= {acc_sh[N-1:0], q_sh};
                  state   <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_comb begin
      op_sel = OP_HOLD;
      case (state)
         IDLE:    op_sel = start ? OP_LOAD : OP_HOLD;
         RUN: begin
            if (!q0)      op_sel = OP_SHIFT;
            else if (last) op_sel = OP_SUB;
            else           op_sel = OP_ADD;
         end
         default: op_sel = OP_HOLD;
      endcase
   end

endmodule

// File: doc/robertson_seq.md
Name: robertson_seq

Overview:
- Sequential signed (two's complement) multiplier control and datapath implementing Robertson's add-shift algorithm.
- Processes one multiplier bit per clock and produces a 2N-bit product.
- Each cycle it drives a 3-bit operation select, op_sel, which directly feeds the downstream 5:1 datapath/status mux (mux5 s input).
- Sits between the operand source (start/operand handshake) and the mux5-based result/observation path.

Parameters:
- N, 8, operand width in bits (N >= 2); product is 2N bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  N  signed multiplicand M, captured on accepted start
- b  input  N  signed multiplier Q, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when product becomes valid
- product  output  2N  signed result a*b, held until next accepted start
- op_sel  output  3  current-cycle operation code to mux5 select

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset (sampled high at any edge, including mid-RUN):
  - state=IDLE, busy=0, done=0, product=0, internal A/Q/M/F/count cleared.
  - Any operation in progress is abandoned.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 at edge loads M=a, Q=b, A=0, F=0, count=N-1, then goes to RUN. start=0 stays in IDLE.
  - RUN: one step per cycle for exactly N cycles; count decrements each cycle. On the step with count=0, goes to DONE.
  - DONE: lasts one cycle with done=1, then returns to IDLE unconditionally.
  - start is ignored in RUN and DONE; there is no queuing.
- Per RUN step, let q0=Q[0]:
  - Non-final step (count>0): if q0, A' = A + M, and F updates to F | (M[N-1] & q0). Otherwise A' = A.
  - Final step (count=0): if q0, A' = A - M (Robertson correction). Otherwise A' = A.
  - Every step then does an arithmetic right shift of {F-extended A', Q}: the new A MSB comes from the sign rule (F on non-final steps, the true sign of A' on the final step), and A[0] shifts into Q[N-1].
  - Internal A is N+1 bits so add/sub never overflows. Sign-extend M to N+1 bits.
- Product register:
  - Loaded with {A[N-1:0], Q} at the final-step edge.
  - Must equal the exact signed product for all 2^(2N) operand pairs, including (-2^(N-1))*(-2^(N-1)) = 2^(2N-2).
- Latency: start sampled at edge k gives busy=1 in cycles k+1..k+N, done=1 and product valid in cycle k+N+1. The next start is accepted at the earliest at edge k+N+2.
- op_sel is combinational from state, start, q0 and count:
  - 0 = load: IDLE with start=1.
  - 1 = add+shift: RUN, count>0, q0=1.
  - 2 = shift only: RUN, q0=0, any count.
  - 3 = sub+shift: RUN, count=0, q0=1.
  - 4 = hold: IDLE with start=0, and DONE.
  - Codes 5-7 are never driven.
- done and busy are never high together; product never changes outside the final-step edge and reset.

Decomposition:
- robertson_pkg holds:
  - state_t enum {IDLE, RUN, DONE};
  - op_sel localparams OP_LOAD=3'd0, OP_ADD=3'd1, OP_SHIFT=3'd2, OP_SUB=3'd3, OP_HOLD=3'd4;
  - the shared 3-bit op_sel width.
- One sub-module: robertson_addsub, a parameterized (N+1)-bit combinational add/subtract with sub control, instantiated once.
- The FSM, counter and shift registers live in robertson_seq.

Test Plan:
- N=8, a=3, b=5, start one cycle → op_sel sequence 0, then 1,2,1,2,2,2,2,2; done at cycle 9 after start edge; product=16'd15.
- a=-3 (8'hFD), b=5 → product=16'hFFF1 (-15). a=5, b=-3 (8'hFD) → final op_sel=3, product=16'hFFF1.
- a=-128, b=-128 → product=16'h4000. a=127, b=-128 → product=16'hC080. a=0, b=8'hFF → product=0, with op_sel 1 on every non-final step.
- Assert start continuously → only one load per N+2 cycles; a, b changes during RUN have no effect on product; busy and done are never high together.
- Assert reset at RUN step 4 → next cycle state IDLE, busy=0, done=0, product=0, op_sel=4. A fresh start then completes correctly.
- Random signed operands for 10k operations at N=8 and N=4 against a signed-multiply reference model; op_sel must stay in 0-4 throughout.
